pipeline_sequencer: RTL
=======================

# pipeline_sequencer

Run/step/halt controller for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB). It sits beside the stage registers and drives their global enable, fetch-freeze and ID/EX bubble controls. It supports continuous and single-step execution and merges the load-use hazard stall from the hazard detector. On a decoded HALT it drains the instructions ahead of HALT to WB, then freezes the pipeline and reports the cycle count to the debug unit.

## Interface
- `DRAIN_CYCLES`, default 3: enabled cycles needed after HALT is seen in ID to retire the older instructions in EX, MEM and WB.
- `COUNT_WIDTH`, default 32: width of the cycle counter.

- `i_clk`  in  1  system clock, rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_mode_continuous`  in  1  1 = continuous mode, 0 = step mode; sampled only in IDLE.
- `i_start`  in  1  one-cycle pulse; starts continuous run.
- `i_step_req`  in  1  one-cycle pulse; advance the pipeline one cycle.
- `i_clear`  in  1  one-cycle pulse; leave HALTED.
- `i_halt_detected`  in  1  ID stage currently holds opcode 6'b111111.
- `i_load_hazard_stall`  in  1  load-use hazard from the hazard detector.
- `o_pipeline_enable`  out  1  global clock-enable for PC and all stage registers.
- `o_if_stall`  out  1  hold PC and IF/ID.
- `o_id_bubble`  out  1  load NOP (all-zero controls) into ID/EX.
- `o_step_done`  out  1  one-cycle pulse after each step cycle.
- `o_busy`  out  1  state is RUN, STEP or DRAIN.
- `o_halted`  out  1  state is HALTED.
- `o_cycle_count`  out  COUNT_WIDTH  number of enabled cycles since the last reset or clear.

## Operation
- States: IDLE, RUN, STEP, DRAIN, HALTED. Register `drain_cnt` is `$clog2(DRAIN_CYCLES+1)` bits wide. Flag `halt_seen` is used in step mode.
- Reset value of every output is 0. On reset: state goes to IDLE, and `drain_cnt`, `halt_seen` and `o_cycle_count` are cleared. Reset mid-operation aborts immediately, and the partial drain is discarded.
- IDLE: all enables 0.
  - `i_start` & `i_mode_continuous` → RUN.
  - `i_step_req` & !`i_mode_continuous` → STEP.
  - `i_start` in step mode is ignored. `i_step_req` in continuous mode is ignored.
- RUN: `o_pipeline_enable`=1.
  - `i_halt_detected` → DRAIN, loading `drain_cnt`=DRAIN_CYCLES.
  - Halt has priority over a simultaneous hazard. The HALT cycle itself still advances with `o_if_stall`=1.
- STEP: `o_pipeline_enable`=1 for exactly one cycle, then → IDLE, with `o_step_done` registered high for the following cycle.
  - If `i_halt_detected` during STEP and `halt_seen`=0: set `halt_seen` and load `drain_cnt`=DRAIN_CYCLES.
  - Each later STEP with `halt_seen`=1 forces `o_if_stall`=1 and decrements `drain_cnt`.
  - When `drain_cnt` reaches 0 at the end of a STEP → HALTED instead of IDLE. `o_step_done` still pulses.
- DRAIN: `o_pipeline_enable`=1 and `o_if_stall`=1. `i_load_hazard_stall` is ignored.
  - `drain_cnt` decrements each cycle.
  - On the cycle `drain_cnt`==1 the next state is HALTED.
- HALTED: all enables 0, `o_halted`=1.
  - `i_clear` → IDLE, clearing `o_cycle_count` and `halt_seen`.
  - `i_clear` in any other state is ignored.
- Hazard merge: in RUN, and in STEP without `halt_seen`, `o_if_stall` = `o_id_bubble` = `i_load_hazard_stall`. `o_id_bubble`=0 in DRAIN.
- `o_cycle_count` increments on every cycle with `o_pipeline_enable`=1 and saturates at all-ones.

## Timing
- State is registered. `o_pipeline_enable`, `o_busy` and `o_halted` decode state only.
- `o_if_stall` and `o_id_bubble` are combinational from state and `i_load_hazard_stall`, so they act in the same cycle the hazard is raised.
- `i_start` sampled at edge k → RUN, with enable high, from cycle k+1.
- `i_step_req` at edge k → enable high during cycle k+1 only; `o_step_done` high during cycle k+2.
- HALT seen in ID during RUN cycle h → DRAIN for cycles h+1 .. h+DRAIN_CYCLES → `o_halted` from cycle h+DRAIN_CYCLES+1. Total enabled cycles including h: DRAIN_CYCLES+1.
- Step pulses arriving while not in IDLE are dropped; there is no queueing.

## Test plan
- Reset mid-RUN with count=17 → next cycle: all outputs 0, state IDLE, `o_cycle_count`=0. A later `i_start` resumes normally.
- Continuous: `i_start` at edge 0, `i_halt_detected` during cycle 10 → enable high in cycles 1–13 with `o_if_stall`=1 in cycles 10–13, `o_halted`=1 from cycle 14, `o_cycle_count`=13.
- Step mode: three `i_step_req` pulses 5 cycles apart → three single enable cycles, three `o_step_done` pulses, `o_cycle_count`=3. A pulse sent during STEP is dropped.
- Step with halt: HALT seen on step 2 → steps 3–5 have `o_if_stall`=1, `o_halted`=1 after step 5, and step 6 is ignored.
- Hazard in RUN: `i_load_hazard_stall`=1 for one cycle → `o_if_stall`=`o_id_bubble`=1 that cycle, with enable still 1. The same hazard during DRAIN gives `o_id_bubble`=0.
- HALTED + `i_clear` → IDLE, count 0. `i_clear` in RUN → no effect. With COUNT_WIDTH=4, a 20-cycle run saturates the count at 15.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Run/step/halt controller for the five-stage pipeline: drives the global
// stage enable, fetch freeze and ID/EX bubble, drains in-flight instructions
// after a decoded HALT and counts enabled cycles for the debug unit.
module pipeline_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_mode_continuous,
  input  logic                   i_start,
  input  logic                   i_step_req,
  input  logic                   i_clear,
  input  logic                   i_halt_detected,
  input  logic                   i_load_hazard_stall,
  output logic                   o_pipeline_enable,
  output logic                   o_if_stall,
  output logic                   o_id_bubble,
  output logic                   o_step_done,
  output logic                   o_busy,
  output logic                   o_halted,
  output logic [COUNT_WIDTH-1:0] o_cycle_count
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_cnt_nxt;
  logic          halt_seen, halt_seen_nxt;

  // State and drain bookkeeping registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      halt_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      halt_seen <= halt_seen_nxt;
    end
  end

  // Next-state decode plus same-cycle fetch-stall / bubble controls.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    halt_seen_nxt = halt_seen;
    o_if_stall    = 1'b0;
    o_id_bubble   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start && i_mode_continuous) begin
          state_nxt = S_RUN;
        end else if (i_step_req && !i_mode_continuous) begin
          state_nxt = S_STEP;
        end
      end
      S_RUN: begin
        if (i_halt_detected) begin
          // HALT wins over a coincident load-use hazard; nothing behind it is fetched.
          o_if_stall    = 1'b1;
          state_nxt     = S_DRAIN;
          drain_cnt_nxt = DW'(DRAIN_CYCLES);
        end else begin
          o_if_stall  = i_load_hazard_stall;
          o_id_bubble = i_load_hazard_stall;
        end
      end
      S_STEP: begin
        state_nxt = S_IDLE;
        if (!halt_seen) begin
          o_if_stall  = i_load_hazard_stall;
          o_id_bubble = i_load_hazard_stall;
          if (i_halt_detected) begin
            halt_seen_nxt = 1'b1;
            drain_cnt_nxt = DW'(DRAIN_CYCLES);
          end
        end else begin
          // Stepping out the instructions older than HALT.
          o_if_stall    = 1'b1;
          drain_cnt_nxt = drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) begin
            state_nxt = S_HALTED;
          end
        end
      end
      S_DRAIN: begin
        o_if_stall    = 1'b1;
        drain_cnt_nxt = drain_cnt - DW'(1);
        if (drain_cnt == DW'(1)) begin
          state_nxt = S_HALTED;
        end
      end
      S_HALTED: begin
        if (i_clear) begin
          state_nxt     = S_IDLE;
          halt_seen_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State-decoded status outputs, registered from the next state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pipeline_enable <= 1'b0;
      o_busy            <= 1'b0;
      o_halted          <= 1'b0;
      o_step_done       <= 1'b0;
    end else begin
      o_pipeline_enable <= (state_nxt == S_RUN) || (state_nxt == S_STEP) ||
                           (state_nxt == S_DRAIN);
      o_busy            <= (state_nxt == S_RUN) || (state_nxt == S_STEP) ||
                           (state_nxt == S_DRAIN);
      o_halted          <= (state_nxt == S_HALTED);
      o_step_done       <= (state == S_STEP);
    end
  end

  // Saturating count of enabled cycles, cleared when leaving HALTED.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_cycle_count <= '0;
    end else if ((state == S_HALTED) && i_clear) begin
      o_cycle_count <= '0;
    end else if (o_pipeline_enable && (o_cycle_count != {COUNT_WIDTH{1'b1}})) begin
      o_cycle_count <= o_cycle_count + COUNT_WIDTH'(1);
    end
  end

endmodule
